// File: rtl/datapath_sequencer_pkg.sv
// seq_pkg: shared state, opcode, ALU-select, imm_sel and status-bit definitions for the sequencer.
package seq_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WBACK, S_HALT
   } state_t;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_SYS = 7'b1110011;
   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_AND   = 3'd1;
   localparam logic [2:0] ALU_OR    = 3'd2;
   localparam logic [2:0] ALU_XOR   = 3'd3;
   localparam logic [2:0] ALU_SLL   = 3'd4;
   localparam logic [2:0] ALU_SRL   = 3'd5;
   localparam logic [2:0] ALU_SLT   = 3'd6;
   localparam logic [2:0] ALU_PASSB = 3'd7;
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam int ST_Z = 0;
   localparam int ST_N = 1;
   localparam int ST_C = 2;
   localparam int ST_V = 3;
   // funct3 encodings with no ALU meaning fall back to PASSB
   function automatic logic [2:0] f3_to_sel(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b111:  return ALU_AND;
         3'b110:  return ALU_OR;
         3'b100:  return ALU_XOR;
         3'b001:  return ALU_SLL;
         3'b101:  return ALU_SRL;
         3'b010:  return ALU_SLT;
         default: return ALU_PASSB;
      endcase
   endfunction
endpackage

// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: instruction/status inputs and datapath control outputs of the sequencer.
interface datapath_sequencer_if;
   logic        start;
   logic [31:0] Instr;
   logic [3:0]  status;
   logic        RegRW;
   logic        ALUsrc;
   logic [3:0]  ALUop;
   logic        c_in;
   logic        MRW;
   logic        WB;
   logic        PCsrc;
   logic [1:0]  imm_sel;
   logic        pc_en;
   logic        busy;
   logic        halted;
   logic        illegal;
   logic [31:0] instr_retired;
   modport slave (
      input  start, Instr, status,
      output RegRW, ALUsrc, ALUop, c_in, MRW, WB, PCsrc, imm_sel,
             pc_en, busy, halted, illegal, instr_retired
   );
   modport master (
      output start, Instr, status,
      input  RegRW, ALUsrc, ALUop, c_in, MRW, WB, PCsrc, imm_sel,
             pc_en, busy, halted, illegal, instr_retired
   );
endinterface

// File: rtl/datapath_sequencer_alu_decode.sv
// seq_alu_decode: maps opcode/funct3/funct7[5] to ALUop, carry-in and a bad-branch-funct3 flag.
module seq_alu_decode
   import seq_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic [3:0] alu_op_o,
   output logic       c_in_o,
   output logic       illegal_f3_o
);
   logic [2:0] sel;
   logic       sub;
   always_comb begin
      sel          = ALU_ADD;
      sub          = 1'b0;
      illegal_f3_o = 1'b0;
      if (opcode_i == OP_R || opcode_i == OP_I) begin
         sel = f3_to_sel(funct3_i);
         sub = (sel == ALU_SLT) || (opcode_i == OP_R && funct3_i == 3'b000 && funct7b5_i);
      end else if (opcode_i == OP_BR) begin
         sub          = 1'b1;
         illegal_f3_o = !(funct3_i inside {3'b000, 3'b001, 3'b100, 3'b101});
      end
   end
   assign alu_op_o = {sub, sel};
   assign c_in_o   = sub;
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WBACK control FSM for the RV32I-subset datapath.
// Define SEQ_INSTR_CNT_EN to build the retired-instruction counter.
module datapath_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned MEM_WAIT        = 0,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   datapath_sequencer_if.slave bus
);
   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [3:0]  wait_q, wait_d;
   logic        illegal_q, illegal_d;
   logic        pc_en, pcsrc, regrw, mrw, wb;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [3:0]  dec_alu_op;
   logic        dec_c_in, illegal_f3;
   logic        is_ld, is_st, is_br, legal_op, taken, mem_last, alu_hold;
   logic        unused_bits;
   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];
   seq_alu_decode u_alu_decode (
      .opcode_i    (opcode),
      .funct3_i    (funct3),
      .funct7b5_i  (ir_q[30]),
      .alu_op_o    (dec_alu_op),
      .c_in_o      (dec_c_in),
      .illegal_f3_o(illegal_f3)
   );
   assign is_ld    = opcode == OP_LW;
   assign is_st    = opcode == OP_SW;
   assign is_br    = opcode == OP_BR;
   assign legal_op = opcode inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR};
   // funct3[0] inverts the sense: 000 Z, 001 !Z, 100 N^V, 101 !(N^V)
   assign taken    = funct3[0] ^ (funct3[2] ? (bus.status[ST_N] ^ bus.status[ST_V]) : bus.status[ST_Z]);
   assign mem_last = wait_q == 4'(MEM_WAIT);
   assign alu_hold = state_q inside {S_EXEC, S_MEM, S_WBACK};
   assign unused_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7], bus.status[ST_C]};
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      wait_d    = wait_q;
      illegal_d = illegal_q;
      pc_en     = 1'b0;
      pcsrc     = 1'b0;
      regrw     = 1'b0;
      mrw       = 1'b0;
      wb        = 1'b0;
      case (state_q)
         S_IDLE:   state_d = bus.start ? S_FETCH : S_IDLE;
         S_FETCH: begin
            ir_d    = bus.Instr;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (legal_op) state_d = S_EXEC;
            else if (opcode == OP_SYS) state_d = S_HALT;
            else begin
               illegal_d = 1'b1;
               pc_en     = !HALT_ON_ILLEGAL;
               state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
            end
         end
         S_EXEC: begin
            if (is_br && illegal_f3) begin
               illegal_d = 1'b1;
               pc_en     = !HALT_ON_ILLEGAL;
               state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
            end else if (is_br) begin
               pc_en   = 1'b1;
               pcsrc   = taken;
               state_d = S_FETCH;
            end else if (is_ld || is_st) begin
               wait_d  = '0;
               state_d = S_MEM;
            end else state_d = S_WBACK;
         end
         S_MEM: begin
            wait_d  = mem_last ? 4'd0 : wait_q + 4'd1;
            mrw     = mem_last && is_st;
            pc_en   = mem_last && is_st;
            state_d = !mem_last ? S_MEM : (is_st ? S_FETCH : S_WBACK);
         end
         S_WBACK: begin
            regrw   = 1'b1;
            pc_en   = 1'b1;
            wb      = !is_ld;
            state_d = S_FETCH;
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end
   assign bus.RegRW   = regrw;
   assign bus.MRW     = mrw;
   assign bus.WB      = wb;
   assign bus.PCsrc   = pcsrc;
   assign bus.pc_en   = pc_en;
   assign bus.ALUop   = alu_hold ? dec_alu_op : 4'd0;
   assign bus.c_in    = alu_hold && dec_c_in;
   assign bus.ALUsrc  = alu_hold && (opcode == OP_I || is_ld || is_st);
   assign bus.imm_sel = !alu_hold ? IMM_I : (is_st ? IMM_S : (is_br ? IMM_B : IMM_I));
   assign bus.busy    = !(state_q inside {S_IDLE, S_HALT});
   assign bus.halted  = state_q == S_HALT;
   assign bus.illegal = illegal_q;
`ifdef SEQ_INSTR_CNT_EN
   logic [31:0] cnt_q, cnt_d;
   assign cnt_d = cnt_q + {31'd0, pc_en};
   always_ff @(posedge clk) cnt_q <= reset ? 32'd0 : cnt_d;
   assign bus.instr_retired = cnt_q;
`else
   assign bus.instr_retired = 32'd0;
`endif
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: table vectors, corner sequences and random programs against a per-instruction trace model.
module tb_datapath_sequencer;
   localparam int MW = 2;
   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011;
   localparam logic [6:0] SW = 7'b0100011, BR = 7'b1100011, SYS = 7'b1110011;
   typedef struct packed {
      logic       RegRW;
      logic       ALUsrc;
      logic [3:0] ALUop;
      logic       c_in;
      logic       MRW;
      logic       WB;
      logic       PCsrc;
      logic [1:0] imm_sel;
      logic       pc_en;
      logic       busy;
      logic       halted;
      logic       illegal;
   } out_t;
   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [3:0]  status;
      int          lat;
      int          n_rf;
      int          n_mem;
      logic        pcsrc;
      bit          halt;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_cnt = 0;
   bit exp_ill = 0;
   out_t exp_q[$];
   vec_t tbl[$];
   datapath_sequencer_if bus ();
   datapath_sequencer #(.MEM_WAIT(MW), .HALT_ON_ILLEGAL(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic out_t actual();
      return {bus.RegRW, bus.ALUsrc, bus.ALUop, bus.c_in, bus.MRW, bus.WB, bus.PCsrc,
              bus.imm_sel, bus.pc_en, bus.busy, bus.halted, bus.illegal};
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check_cnt(input string name);
`ifdef SEQ_INSTR_CNT_EN
      check({name, " retired"}, bus.instr_retired, exp_cnt);
`else
      check({name, " retired"}, bus.instr_retired, 32'd0);
`endif
   endtask
   function automatic logic [2:0] sel_of(input logic [2:0] f3);
      case (f3)
         3'b000: return 3'd0;
         3'b111: return 3'd1;
         3'b110: return 3'd2;
         3'b100: return 3'd3;
         3'b001: return 3'd4;
         3'b101: return 3'd5;
         3'b010: return 3'd6;
         default: return 3'd7;
      endcase
   endfunction
   // Expected per-cycle outputs for one instruction, starting at its FETCH cycle
   task automatic model(input logic [31:0] ins, input logic [3:0] st, output bit halt);
      out_t o, ex, m;
      logic [6:0] op;
      logic [2:0] f3;
      bit tk, nv;
      op = ins[6:0];
      f3 = ins[14:12];
      exp_q = {};
      halt = 0;
      o = '0;
      o.busy = 1'b1;
      o.illegal = exp_ill;
      exp_q.push_back(o);
      exp_q.push_back(o);
      if (op == SYS) begin halt = 1; return; end
      if (!(op inside {R, I, LW, SW, BR})) begin exp_ill = 1; halt = 1; return; end
      ex = o;
      if (op == R) ex.ALUop = {(f3 == 3'b000 && ins[30]) || f3 == 3'b010, sel_of(f3)};
      else if (op == I) ex.ALUop = {f3 == 3'b010, sel_of(f3)};
      else if (op == BR) ex.ALUop = 4'b1000;
      ex.c_in = ex.ALUop[3];
      ex.ALUsrc = op inside {I, LW, SW};
      ex.imm_sel = op == SW ? 2'b01 : (op == BR ? 2'b10 : 2'b00);
      if (op == BR) begin
         nv = st[1] ^ st[3];
         case (f3)
            3'b000: tk = st[0];
            3'b001: tk = !st[0];
            3'b100: tk = nv;
            3'b101: tk = !nv;
            default: begin exp_q.push_back(ex); exp_ill = 1; halt = 1; return; end
         endcase
         ex.pc_en = 1'b1;
         ex.PCsrc = tk;
         exp_q.push_back(ex);
         return;
      end
      exp_q.push_back(ex);
      if (op == LW || op == SW)
         for (int k = 0; k <= MW; k++) begin
            m = ex;
            if (op == SW && k == MW) begin m.MRW = 1'b1; m.pc_en = 1'b1; end
            exp_q.push_back(m);
         end
      if (op != SW) begin
         m = ex;
         m.RegRW = 1'b1;
         m.pc_en = 1'b1;
         m.WB = op != LW;
         exp_q.push_back(m);
      end
   endtask
   // Called at #1 after the edge entering FETCH; leaves the DUT in the next FETCH or in HALT
   task automatic run(input string name, input logic [31:0] ins, input logic [3:0] st,
                      output int lat, output int n_rf, output int n_mem, output logic pcsrc);
      bit halt;
      out_t h;
      bus.Instr = ins;
      bus.status = st;
      model(ins, st, halt);
      lat = 0; n_rf = 0; n_mem = 0; pcsrc = 1'b0;
      foreach (exp_q[i]) begin
         check({name, " cycle"}, 32'(actual()), 32'(exp_q[i]));
         if (bus.pc_en) begin lat = i + 1; pcsrc = bus.PCsrc; end
         n_rf += int'(bus.RegRW);
         n_mem += int'(bus.MRW);
         if (exp_q[i].pc_en) exp_cnt++;
         bus.start = 1'($urandom_range(0, 1));
         step();
         bus.Instr = $urandom;
      end
      bus.start = 1'b0;
      check_cnt(name);
      if (halt) begin
         h = '0;
         h.halted = 1'b1;
         h.illegal = exp_ill;
         check({name, " halt"}, 32'(actual()), 32'(h));
      end
   endtask
   task automatic start_seq();
      bus.start = 1'b0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      exp_cnt = 0;
      exp_ill = 0;
      check("reset outputs", 32'(actual()), 32'd0);
      check_cnt("reset");
      step();
      check("idle no start", 32'(actual()), 32'd0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask
   initial begin
      int lat, n_rf, n_mem;
      logic pcsrc;
      bus.start = 1'b0;
      bus.Instr = '0;
      bus.status = '0;
      tbl.push_back('{"ADD",   32'h002081B3, 4'h0, 4, 1, 0, 1'b0, 1'b0});
      tbl.push_back('{"SUB",   32'h402081B3, 4'h0, 4, 1, 0, 1'b0, 1'b0});
      tbl.push_back('{"AND",   32'h0020F1B3, 4'h0, 4, 1, 0, 1'b0, 1'b0});
      tbl.push_back('{"SLT",   32'h0020A1B3, 4'h0, 4, 1, 0, 1'b0, 1'b0});
      tbl.push_back('{"ADDI",  32'h00500093, 4'h0, 4, 1, 0, 1'b0, 1'b0});
      tbl.push_back('{"SLTI",  32'h00502093, 4'h0, 4, 1, 0, 1'b0, 1'b0});
      tbl.push_back('{"LW",    32'h00802283, 4'h0, 5 + MW, 1, 0, 1'b0, 1'b0});
      tbl.push_back('{"SW",    32'h00502223, 4'h0, 4 + MW, 0, 1, 1'b0, 1'b0});
      tbl.push_back('{"BEQ_T", 32'h00000463, 4'h1, 3, 0, 0, 1'b1, 1'b0});
      tbl.push_back('{"BEQ_N", 32'h00000463, 4'h0, 3, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{"BNE_T", 32'h00001463, 4'h0, 3, 0, 0, 1'b1, 1'b0});
      tbl.push_back('{"BLT_T", 32'h00004463, 4'h2, 3, 0, 0, 1'b1, 1'b0});
      tbl.push_back('{"BGE_T", 32'h00005463, 4'hA, 3, 0, 0, 1'b1, 1'b0});
      tbl.push_back('{"BGE_N", 32'h00005463, 4'h2, 3, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{"ECALL", 32'h00000073, 4'h0, 0, 0, 0, 1'b0, 1'b1});
      tbl.push_back('{"ILL",   32'hFFFFFFFF, 4'h0, 0, 0, 0, 1'b0, 1'b1});
      tbl.push_back('{"BR010", 32'h00002463, 4'h0, 0, 0, 0, 1'b0, 1'b1});
      start_seq();
      foreach (tbl[t]) begin
         run(tbl[t].name, tbl[t].instr, tbl[t].status, lat, n_rf, n_mem, pcsrc);
         check({tbl[t].name, " latency"}, 32'(lat), 32'(tbl[t].lat));
         check({tbl[t].name, " rf writes"}, 32'(n_rf), 32'(tbl[t].n_rf));
         check({tbl[t].name, " mem writes"}, 32'(n_mem), 32'(tbl[t].n_mem));
         check({tbl[t].name, " pcsrc"}, 32'(pcsrc), 32'(tbl[t].pcsrc));
         check({tbl[t].name, " halted"}, 32'(bus.halted), 32'(tbl[t].halt));
         if (tbl[t].halt) begin
            bus.start = 1'b1;
            step();
            step();
            check({tbl[t].name, " halt sticky"}, 32'({bus.halted, bus.pc_en, bus.busy}), 32'b100);
            start_seq();
         end
      end
      // Reset while an LW is waiting in MEM
      run("ADD pre", 32'h002081B3, 4'h0, lat, n_rf, n_mem, pcsrc);
      bus.Instr = 32'h00802283;
      step();
      step();
      step();
      check("LW in MEM", 32'({bus.busy, bus.ALUsrc, bus.pc_en}), 32'b110);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_cnt = 0;
      exp_ill = 0;
      check("reset in MEM", 32'(actual()), 32'd0);
      check_cnt("reset in MEM");
      step();
      check("idle after reset", 32'(actual()), 32'd0);
      start_seq();
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ins;
         logic [2:0] f3s[6];
         logic [2:0] bf3[4];
         f3s = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b001, 3'b101};
         bf3 = '{3'b000, 3'b001, 3'b100, 3'b101};
         ins = $urandom;
         case ($urandom_range(0, 4))
            0: begin ins[6:0] = R; ins[14:12] = n % 7 == 0 ? 3'b010 : f3s[$urandom_range(0, 5)]; end
            1: begin ins[6:0] = I; ins[14:12] = n % 5 == 0 ? 3'b010 : f3s[$urandom_range(0, 5)]; end
            2: ins[6:0] = LW;
            3: ins[6:0] = SW;
            default: begin ins[6:0] = BR; ins[14:12] = bf3[$urandom_range(0, 3)]; end
         endcase
         run("random", ins, 4'($urandom), lat, n_rf, n_mem, pcsrc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
